// File: rtl/uart_pkg.sv
// Shared UART definitions: frame bit levels, parity selection, FSM state
// encoding (also used by the receiver) and default widths.
package uart_pkg;

    localparam int unsigned PRESCALE_WIDTH_DEF = 6;
    localparam int unsigned DATA_WIDTH_DEF     = 8;

    // Parity type selection (PAR_TYP input)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Line levels of the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Parity bit from the XOR of the data bits and the selected parity type
    function automatic logic parity_bit(input logic par_typ, input logic data_xor);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter: counts 0..P-1 and flags the last cycle of a bit.
// A period of 0 is treated as 1 (terminal count every cycle).
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : hold the count at 0 (priority over i_en)
//   i_en           : advance the count
//   i_period       : cycles per bit
//   o_tc_c         : combinational terminal count (count == P-1)
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = PRESCALE_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_tc_c
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_last;

    // Last count value of a bit; period 0 behaves as period 1
    assign w_last = (i_period == '0) ? WIDTH'(0) : (i_period - WIDTH'(1));
    assign o_tc_c = (r_count == w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc_c ? WIDTH'(0) : (r_count + WIDTH'(1));
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one word per accepted request as
// start(0), data LSB-first, optional parity, stop(1); each bit lasts
// Prescale cycles. TX_OUT and Busy are registered.
// Ports:
//   CLK, RST   : clock, async active-low reset
//   Prescale   : cycles per bit (0 treated as 1), latched at accept
//   PAR_EN     : insert parity bit after data
//   PAR_TYP    : 0 even, 1 odd
//   P_DATA     : word to send, latched at accept
//   Data_Valid : send request, only honoured while idle
//   TX_OUT     : serial line, idles high
//   Busy       : frame in progress
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_e               r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [IDX_W-1:0]          r_bit_idx, w_bit_idx_nxt;
    logic [IDX_W-1:0]          w_bit_idx_inc;
    logic                      r_tx, w_tx_nxt;
    logic                      r_busy, w_busy_nxt;
    logic                      w_accept;
    logic                      w_tc;
    logic                      w_parity;

    // Bit timer held at 0 while idle so START begins a fresh bit
    uart_bit_timer #(
        .WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_clear  (r_state == IDLE),
        .i_en     (1'b1),
        .i_period (r_prescale),
        .o_tc_c   (w_tc)
    );

    assign w_parity      = parity_bit(r_par_typ, ^r_data);
    assign w_bit_idx_inc = r_bit_idx + IDX_W'(1);

    // State, bit index and registered line outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bit_idx <= '0;
            r_tx      <= STOP_BIT;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Frame settings captured at accept; frozen for the frame in flight
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_prescale <= '0;
        end else if (w_accept) begin
            r_data     <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_prescale <= Prescale;
        end
    end

    // Next state; the line value for the upcoming bit is chosen at the
    // boundary so TX_OUT only changes on bit edges
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_idx_nxt = r_bit_idx;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_accept      = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_nxt   = STOP_BIT;
                w_busy_nxt = 1'b0;
                if (Data_Valid) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = START;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = START_BIT;
                    w_busy_nxt    = 1'b1;
                end
            end
            START: begin
                if (w_tc) begin
                    w_state_nxt   = DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_data[0];
                end
            end
            DATA: begin
                if (w_tc) begin
                    if (r_bit_idx == LAST_IDX) begin
                        if (r_par_en) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = w_parity;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = STOP_BIT;
                        end
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_tx_nxt      = r_data[w_bit_idx_inc];
                    end
                end
            end
            PARITY: begin
                if (w_tc) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = STOP_BIT;
                end
            end
            STOP: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                    w_tx_nxt    = STOP_BIT;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = STOP_BIT;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter directly upstream of the UART receiver; its TX_OUT drives the receiver's RX_IN.
- Accepts one 8-bit word per handshake and serialises it as one frame: start(0), data LSB-first, optional parity, stop(1).
- Every bit lasts Prescale clock cycles, so TX and RX share one clock and one Prescale setting.

Parameters:
- PRESCALE_WIDTH, 6, width of Prescale input and of the internal per-bit cycle counter.
- DATA_WIDTH, 8, payload bits per frame (only 8 is verified).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-low reset.
- Prescale  input  PRESCALE_WIDTH  clock cycles per bit (8, 16 or 32 in use; 0 treated as 1).
- PAR_EN  input  1  1 = parity bit inserted after data.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  input  DATA_WIDTH  word to send.
- Data_Valid  input  1  request to send P_DATA.
- TX_OUT  output  1  serial line, idles high.
- Busy  output  1  frame in progress; requests are ignored while high.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, TX_OUT=1, Busy=0, counters and data register cleared. Reset mid-frame aborts the frame immediately, with the line high.
- Accept: on a rising edge with state IDLE and Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale. Later changes to these inputs do not affect the frame in flight.
- Latency: TX_OUT falls and Busy rises in the cycle after the accept edge. Both are registered outputs with no combinational path from inputs.
- FSM states:
  - IDLE → START on accept.
  - START → DATA after P cycles (P = latched Prescale, or 1 if 0).
  - DATA holds bit index 0..7. It advances every P cycles. After bit 7 it goes to PARITY if PAR_EN, else STOP.
  - PARITY → STOP after P cycles.
  - STOP → IDLE after P cycles.
- Bit cycle counter runs 0..P-1. The state or bit index advances when the count is P-1; the counter then wraps to 0.
- Parity value:
  - even: ^data, so the total number of ones in data+parity is even.
  - odd: ~^data.
- Frame length: 10*P cycles without parity, 11*P with parity. Busy is high for exactly that many cycles.
- Back-to-back: Busy drops on the edge that leaves STOP. A request held high then is accepted on the next edge, giving exactly one idle-high cycle between frames.
- Data_Valid while Busy=1 is ignored, not queued. The source must hold Data_Valid until it sees Busy fall.
- TX_OUT stays 1 in IDLE. No glitches: TX_OUT changes only on bit boundaries.

Decomposition:
- Shared package uart_pkg holds:
  - parity constants PAR_EVEN=0, PAR_ODD=1;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP), shared with the receiver's state names;
  - frame bit constants START_BIT=0, STOP_BIT=1.
- One sub-module, uart_bit_timer: a loadable counter with a terminal-count pulse for the per-bit Prescale count. It is reusable by the receiver's edge counter.

Test Plan:
- P=8, PAR_EN=1, even, P_DATA=8'b11000001 → TX_OUT sequence 0,1,0,0,0,0,0,1,1,1(parity),1. Each bit is 8 cycles, Busy high for 88 cycles. Looping into the UART receiver gives data_valid with P_DATA=8'hC1.
- P=16, odd, three back-to-back words 8'h2D, 8'hB7, 8'hC1 with Data_Valid held → exactly one idle-high cycle between 176-cycle frames. Parity bits are 1, 1, 0; the receiver gets all three words.
- P=32, PAR_EN=0, P_DATA=8'hAA → 320-cycle frame, bits 0,0,1,0,1,0,1,0,1,1. There is no parity slot.
- Mid-frame Data_Valid=1 with P_DATA=8'hFF during the DATA state of an 8'h51 frame → the frame continues with 8'h51 unchanged and the second request is ignored. Changing Prescale/PAR_EN mid-frame has no effect.
- Assert RST low at bit 4 of a frame → TX_OUT=1 and Busy=0 in the same time step, without waiting for a clock edge. After release the next request sends a complete, correct frame.
- Prescale=0, P_DATA=8'h01 → each bit lasts 1 cycle and the 10-cycle frame is correct.
